// File: rtl/ternary_word_decoder.sv
// Trit-serial balanced-ternary to two's-complement converter (Horner, MSB first).
// Optional invalid-trit flagging: define TERNARY_DEC_ERRCHK_EN.
module ternary_word_decoder #(
  parameter int NTRITS = 9,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*NTRITS-1:0]     in_word,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_value,
  output logic                    out_err
);

  localparam int AW = OUT_W + 2;
  localparam int CW = (NTRITS > 1) ? $clog2(NTRITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t                state;
  logic [2*NTRITS-1:0]   sreg;
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;

  logic [1:0]            top;
  logic signed [AW-1:0]  t;
  logic signed [AW-1:0]  acc_next;
  logic                  last;

  // Decode the leading trit and form the next Horner step
  always_comb begin
    top      = sreg[2*NTRITS-1 -: 2];
    t        = '0;
    unique case (1'b1)
      (top == 2'b01): t = AW'(1);
      (top == 2'b10): t = '1;
      default:        t = '0;
    endcase
    acc_next = (acc <<< 1) + acc + t;
    last     = (cnt == CW'(NTRITS - 1));
  end

`ifdef TERNARY_DEC_ERRCHK_EN
  logic err;
  logic out_err_q;
  logic bad;

  // Code 11 has no ternary meaning; it is counted as 0 but flagged
  always_comb begin
    bad = (top == 2'b11);
  end

  // Sticky error bit, published together with the value
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            err <= 1'b0;
          end
        end
        CONV: begin
          err <= err | bad;
          if (last) begin
            out_err_q <= err | bad;
          end
        end
        default: begin
          err <= err;
        end
      endcase
    end
  end

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_value <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= in_word;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          acc  <= acc_next;
          sreg <= sreg << 2;
          cnt  <= cnt + CW'(1);
          if (last) begin
            out_value <= acc_next[OUT_W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_word_decoder.sv
// Scoreboard bench for ternary_word_decoder: driver pushes expectations,
// monitor pops and compares on each output handshake.
module tb_ternary_word_decoder;

  localparam int NT = 9;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [2*NT-1:0]      in_word = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [OW-1:0] out_value;
  logic                 out_err;

  typedef struct {
    int v;
    bit e;
    int ac;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   prev_valid = 1'b0;

`ifdef TERNARY_DEC_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  ternary_word_decoder #(
    .NTRITS(NT),
    .OUT_W (OW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  // Monitor: latency on rise of out_valid, value/err on handshake
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got value %0d expected no output",
                 out_value);
      end else begin
        chk("latency", cyc - sb[0].ac, NT);
      end
    end
    if (out_valid && out_ready && sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("out_value", int'(out_value), x.v);
      chk("out_err", int'(out_err), int'(x.e));
    end
    prev_valid = out_valid;
  end

  // Present a word, wait for acceptance, push its expectation
  task automatic send(input logic [2*NT-1:0] w, input int v, input bit e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{v: v, e: e, ac: cyc});
    in_valid = 1'b0;
    in_word  = ~w;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_value", int'(out_value), 0);
    chk("rst_out_err", int'(out_err), 0);

    send(18'h00000, 0, 1'b0);
    send(18'h15555, 9841, 1'b0);
    send(18'h2AAAA, -9841, 1'b0);
    send(18'h10000, 6561, 1'b0);
    send(18'h00002, -1, 1'b0);
    send(18'h00006, 2, 1'b0);
    send(18'h00003, 0, ERRCHK);
    send(18'h00007, 3, ERRCHK);
    drain();

    // Backpressure: hold DONE for 5 cycles while a new word waits
    out_ready = 1'b0;
    send(18'h00006, 2, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_word  = 18'h15555;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_value", int'(out_value), 2);
      chk("hold_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(18'h15555, 9841, 1'b0);
    drain();

    // Reset in the middle of a conversion
    in_valid = 1'b1;
    in_word  = 18'h15555;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_value", int'(out_value), 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("midrst_no_output", n, 0);
    send(18'h00001, 1, 1'b0);
    drain();

    chk("sb_final_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
